// File: rtl/cell_painter.sv
// Paints one tracker grid cell as CELL_W x CELL_H RGB565 pixels in raster order.
// Optional build macro CELL_PAINTER_GRID_EN draws grid lines on the right/bottom edge of blank cells.
//
// state | meaning
// IDLE  | waiting for a changed cell; enable follows ~diff
// PAINT | streaming pixels of the latched cell; tracker held
module cell_painter #(
    parameter int CELL_W = 20,
    parameter int CELL_H = 20
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        diff,
    input  logic [2:0]  obj_code,
    input  logic [3:0]  x,
    input  logic [3:0]  y,
    output logic        enable,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [8:0]  px_x,
    output logic [7:0]  px_y,
    output logic [15:0] px_color,
    output logic        busy
);

    localparam int CW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CH = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    typedef enum logic {IDLE, PAINT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cx;
    logic [3:0]    r_cy;
    logic [2:0]    r_code;
    logic [2:0]    r_pend_code;
    logic          r_pend;
    logic [CW-1:0] r_col;
    logic [CH-1:0] r_row;

    logic          w_accept;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_cell_end;
    logic          w_load_idle;
    logic          w_reload;
    logic [15:0]   w_color;

    assign w_accept   = (r_state == PAINT) && px_ready;
    assign w_col_last = (r_col == CW'(CELL_W - 1));
    assign w_row_last = (r_row == CH'(CELL_H - 1));
    assign w_cell_end = w_accept && w_col_last && w_row_last;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A diff coinciding with cell end counts as pending, so the cell repaints without a gap.
    always_comb begin
        w_state_nxt = r_state;
        enable      = 1'b0;
        w_load_idle = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            IDLE: begin
                enable = ~diff;
                if (diff) begin
                    w_state_nxt = PAINT;
                    w_load_idle = 1'b1;
                end
            end
            PAINT: begin
                if (w_cell_end) begin
                    if (r_pend || diff) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cx        <= '0;
            r_cy        <= '0;
            r_code      <= '0;
            r_pend      <= 1'b0;
            r_pend_code <= '0;
            r_col       <= '0;
            r_row       <= '0;
        end else begin
            if (w_load_idle) begin
                r_cx   <= x;
                r_cy   <= y;
                r_code <= obj_code;
                r_col  <= '0;
                r_row  <= '0;
            end else if (w_reload) begin
                r_code <= diff ? obj_code : r_pend_code;
                r_col  <= '0;
                r_row  <= '0;
                r_pend <= 1'b0;
            end else if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if ((r_state == PAINT) && diff && !w_reload) begin
                r_pend      <= 1'b1;
                r_pend_code <= obj_code;
            end
        end
    end

    always_comb begin
        w_color = 16'h0000;
        case (r_code)
            3'd1:    w_color = 16'h03E0;
            3'd2:    w_color = 16'h07E0;
            3'd3:    w_color = 16'hF800;
            3'd4:    w_color = 16'hFFFF;
            default: w_color = 16'h0000;
        endcase
`ifdef CELL_PAINTER_GRID_EN
        if ((r_code == 3'd0) && (w_col_last || w_row_last)) begin
            w_color = 16'h4208;
        end
`endif
    end

    assign px_valid = (r_state == PAINT);
    assign busy     = (r_state == PAINT);
    assign px_x     = 9'(r_cx) * 9'(CELL_W) + 9'(r_col);
    assign px_y     = 8'(r_cy) * 8'(CELL_H) + 8'(r_row);
    assign px_color = w_color;

endmodule

// File: doc/cell_painter.md
CELL_PAINTER -- requirements
Module: cell_painter

Interface
REQ-001 The block SHALL have parameter CELL_W, default 20, pixel width of one grid cell.
REQ-002 The block SHALL have parameter CELL_H, default 20, pixel height of one grid cell.
REQ-003 The block SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 The block SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port diff  input  1  the tracker cell at (x,y) changed this cycle.
REQ-006 The block SHALL have port obj_code  input  3  new object code for the changed cell.
REQ-007 The block SHALL have ports x  input  4 and y  input  4  current tracker cell, x 0..15, y 0..11.
REQ-008 The block SHALL have port enable  output  1  advance request to the tracker scan.
REQ-009 The block SHALL have ports px_valid  output  1 and px_ready  input  1  pixel write handshake.
REQ-010 The block SHALL have ports px_x  output  9, px_y  output  8 and px_color  output  16 (RGB565)  pixel address and colour.
REQ-011 The block SHALL have port busy  output  1  high while the painter is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE and PAINT.
REQ-013 In IDLE, enable SHALL equal ~diff (combinational), and px_valid SHALL be 0.
REQ-014 In IDLE with diff=1, the block SHALL latch x, y and obj_code, clear the pixel counters, and enter PAINT on the next edge.
REQ-015 In PAINT, enable SHALL be 0, so the tracker holds the cell.
REQ-016 In PAINT, px_valid SHALL be 1.
REQ-017 In PAINT, px_x SHALL equal cx*CELL_W+col and px_y SHALL equal cy*CELL_H+row, where cx and cy are the latched cell coordinates.
REQ-018 px_x, px_y and px_color SHALL be stable while px_valid=1 and px_ready=0.
REQ-019 A pixel SHALL be accepted on an edge with px_valid=1 and px_ready=1.
REQ-020 On each accepted pixel, col SHALL increment; on col=CELL_W-1, col SHALL wrap to 0 and row SHALL increment (raster order).
REQ-021 Acceptance of pixel (CELL_W-1, CELL_H-1) SHALL end the cell; total writes per cell SHALL be exactly CELL_W*CELL_H.
REQ-022 Colour map: 0 blank 0x0000, 1 head 0x03E0, 2 body 0x07E0, 3 apple 0xF800, 4 border 0xFFFF, 5-7 0x0000.
REQ-023 If diff=1 in PAINT, the block SHALL set pend and store obj_code into pend_code; when several arrive, the last one wins.
REQ-024 At cell end with pend=1, the block SHALL stay in PAINT, reload the colour from pend_code at the same cell, clear the counters and clear pend.
REQ-025 At cell end with pend=0, the block SHALL return to IDLE.
REQ-026 A diff arriving in the same cycle as cell end SHALL be captured as pend.
REQ-027 Back-to-back cells SHALL leave no idle cycle beyond the one IDLE cycle needed to sample diff.
REQ-028 The block SHALL set busy=1 in PAINT and busy=0 in IDLE.

Reset
REQ-029 With nrst=0, the block SHALL be in IDLE.
REQ-030 With nrst=0, the following SHALL all be 0: counters, latched cell, code, pend, pend_code, px_valid, px_x, px_y, px_color and busy; enable SHALL be ~diff.
REQ-031 Reset asserted mid-PAINT SHALL abandon the cell immediately with no further pixel writes, and px_valid SHALL fall asynchronously.

Configuration
REQ-032 With CELL_PAINTER_GRID_EN defined, pixels with col=CELL_W-1 or row=CELL_H-1 in a blank (code 0) cell SHALL use colour 0x4208 (grid line); all other cells and pixels SHALL be unaffected.
REQ-033 Without CELL_PAINTER_GRID_EN, every pixel of a cell SHALL use the colour map only.

Verification
REQ-034 The bench SHALL cover: reset, diff=0 held 192 cycles -> enable=1 throughout, px_valid never 1, busy=0.
REQ-035 The bench SHALL cover: diff=1, x=3, y=2, obj_code=3, px_ready=1 -> 400 writes, first (60,40), last (79,59), all 0xF800, then IDLE.
REQ-036 The bench SHALL cover: px_ready toggling randomly -> outputs stable while stalled, exactly 400 accepts, raster order unchanged.
REQ-037 The bench SHALL cover: diff=1 code 1 during PAINT of cell (0,0), then code 2 -> one repaint of (0,0) in 0x07E0 only.
REQ-038 The bench SHALL cover: nrst low after 57 accepts -> px_valid=0 at once, busy=0, no writes until the next diff.
REQ-039 The bench SHALL cover: with CELL_PAINTER_GRID_EN, code 0 at (15,11) -> pixels at x=319 or y=239 are 0x4208, others 0x0000; without it, all 0x0000.
